// File: rtl/perceptron_out_pack.sv
// Packs the 1-bit perceptron decision stream into PACK-bit words, each emitted
// with its valid length and popcount over a val/rdy handshake; flush_i emits a partial word.
module perceptron_out_pack #(
  parameter  int PACK = 8,
  localparam int LW   = $clog2(PACK+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            val_i,
  output logic            rdy_o,
  input  logic            Y_i,
  input  logic            flush_i,
  output logic            val_o,
  input  logic            rdy_i,
  output logic [PACK-1:0] data_o,
  output logic [LW-1:0]   len_o,
  output logic [LW-1:0]   ones_o,
  output logic [15:0]     words_o
);

  logic [PACK-1:0] r_acc;
  logic [LW-1:0]   r_cnt;
  logic [LW-1:0]   r_ones;
  logic            r_flush_pend;
  logic            r_val;
  logic [PACK-1:0] r_data;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_ones_o;
  logic [15:0]     r_words;

  logic            w_full;
  logic            w_rdy;
  logic            w_acc_en;
  logic            w_xfer;
  logic            w_hs;
  logic [PACK-1:0] w_mask;

  assign w_full   = (r_cnt == LW'(PACK));
  assign w_rdy    = !w_full && !r_flush_pend;
  assign w_acc_en = val_i && w_rdy;
  assign w_xfer   = (w_full || (r_flush_pend && r_cnt != '0)) && (!r_val || rdy_i);
  assign w_hs     = r_val && rdy_i;
  // Shift wraps to 0 at cnt == PACK, so the subtraction yields an all-ones mask.
  assign w_mask   = (PACK'(1) << r_cnt) - PACK'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ones       <= '0;
      r_flush_pend <= 1'b0;
      r_val        <= 1'b0;
      r_data       <= '0;
      r_len        <= '0;
      r_ones_o     <= '0;
      r_words      <= '0;
    end else begin
      if (w_hs) begin
        r_words <= r_words + 16'd1;
        r_val   <= 1'b0;
      end
      // Transfer and accept are mutually exclusive: rdy_o is low whenever T can fire.
      if (w_xfer) begin
        r_data       <= r_acc & w_mask;
        r_len        <= r_cnt;
        r_ones_o     <= r_ones;
        r_val        <= 1'b1;
        r_acc        <= '0;
        r_cnt        <= '0;
        r_ones       <= '0;
        r_flush_pend <= 1'b0;
      end else begin
        if (w_acc_en) begin
          r_acc  <= r_acc | (PACK'(Y_i) << r_cnt);
          r_cnt  <= r_cnt + LW'(1);
          r_ones <= r_ones + LW'(Y_i);
        end
        if (flush_i && !w_full && (r_cnt != '0 || w_acc_en))
          r_flush_pend <= 1'b1;
      end
    end
  end

  assign rdy_o   = w_rdy;
  assign val_o   = r_val;
  assign data_o  = r_data;
  assign len_o   = r_len;
  assign ones_o  = r_ones_o;
  assign words_o = r_words;

endmodule

// File: tb/tb_perceptron_out_pack.sv
// Directed bench for perceptron_out_pack: full words, flushes, output stall,
// continuous random stream against a packing model, and mid-operation reset.
module tb_perceptron_out_pack;

  localparam int PACK = 8;
  localparam int LW   = $clog2(PACK+1);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            val_i = 1'b0;
  logic            rdy_o;
  logic            Y_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            val_o;
  logic            rdy_i = 1'b0;
  logic [PACK-1:0] data_o;
  logic [LW-1:0]   len_o;
  logic [LW-1:0]   ones_o;
  logic [15:0]     words_o;

  int total = 0;
  int bad   = 0;

  perceptron_out_pack #(.PACK(PACK)) dut (
    .clk(clk), .reset(reset), .val_i(val_i), .rdy_o(rdy_o), .Y_i(Y_i),
    .flush_i(flush_i), .val_o(val_o), .rdy_i(rdy_i), .data_o(data_o),
    .len_o(len_o), .ones_o(ones_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feed one full word LSB first, one accept per cycle (rdy_o is high throughout).
  task automatic feed8(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      val_i = 1'b1;
      Y_i   = w[k];
      step();
    end
    val_i = 1'b0;
    Y_i   = 1'b0;
  endtask

  logic [23:0] rbits;
  logic [7:0]  ew;
  int          idx, low, wi, ex_ones;

  initial begin
    // reset
    step(); step();
    reset = 1'b0;
    chk("rst_rdy",   rdy_o, 1);
    chk("rst_val",   val_o, 0);
    chk("rst_data",  data_o, 0);
    chk("rst_len",   len_o, 0);
    chk("rst_ones",  ones_o, 0);
    chk("rst_words", words_o, 0);

    // full word 0x8D
    rdy_i = 1'b1;
    feed8(8'h8D);
    chk("full_val_early", val_o, 0);
    chk("full_rdy_low",   rdy_o, 0);
    step();
    chk("full_val",   val_o, 1);
    chk("full_data",  data_o, 8'h8D);
    chk("full_len",   len_o, 8);
    chk("full_ones",  ones_o, 4);
    chk("full_rdy",   rdy_o, 1);
    step();
    chk("full_val_clr", val_o, 0);
    chk("full_words",   words_o, 1);

    // partial 1,1,0 then flush
    for (int k = 0; k < 3; k++) begin
      val_i = 1'b1;
      Y_i   = (k < 2);
      step();
    end
    val_i = 1'b0; Y_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_pend_val", val_o, 0);
    chk("fl_pend_rdy", rdy_o, 0);
    step();
    chk("fl_val",  val_o, 1);
    chk("fl_data", data_o, 8'h03);
    chk("fl_len",  len_o, 3);
    chk("fl_ones", ones_o, 2);
    step();
    chk("fl_words", words_o, 2);

    // flush with nothing held is ignored
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    chk("fl0_val",   val_o, 0);
    chk("fl0_rdy",   rdy_o, 1);
    chk("fl0_words", words_o, 2);

    // flush coincident with 5th accept
    for (int k = 0; k < 5; k++) begin
      val_i   = 1'b1;
      Y_i     = 1'b1;
      flush_i = (k == 4);
      step();
    end
    val_i = 1'b0; Y_i = 1'b0; flush_i = 1'b0;
    chk("flc_rdy", rdy_o, 0);
    step();
    chk("flc_val",  val_o, 1);
    chk("flc_data", data_o, 8'h1F);
    chk("flc_len",  len_o, 5);
    chk("flc_ones", ones_o, 5);
    step();
    chk("flc_words", words_o, 3);
    chk("flc_vclr",  val_o, 0);

    // output stall: word A held while B fills the collector
    rdy_i = 1'b0;
    feed8(8'hA5);
    step();
    chk("st_a_val",  val_o, 1);
    chk("st_a_data", data_o, 8'hA5);
    feed8(8'h3C);
    chk("st_rdy_low", rdy_o, 0);
    chk("st_hold",    data_o, 8'hA5);
    step();
    chk("st_rdy_low2", rdy_o, 0);
    chk("st_hold2",    data_o, 8'hA5);
    chk("st_words",    words_o, 3);
    rdy_i = 1'b1;
    step();
    rdy_i = 1'b0;
    chk("st_b_val",   val_o, 1);
    chk("st_b_data",  data_o, 8'h3C);
    chk("st_b_len",   len_o, 8);
    chk("st_b_ones",  ones_o, 4);
    chk("st_words1",  words_o, 4);
    chk("st_rdy_back", rdy_o, 1);
    step();
    chk("st_b_hold", data_o, 8'h3C);
    rdy_i = 1'b1;
    step();
    chk("st_words2", words_o, 5);
    chk("st_vclr",   val_o, 0);

    // continuous random stream against a packing model
    rbits = 24'($urandom);
    idx = 0; low = 0; wi = 0;
    for (int c = 0; c < 40; c++) begin
      val_i = (idx < 24);
      Y_i   = (idx < 24) ? rbits[idx] : 1'b0;
      if (!rdy_o) low++;
      if (rdy_o && val_i) idx++;
      step();
      if (val_o) begin
        ex_ones = 0;
        for (int k = 0; k < 8; k++) begin
          ew[k] = rbits[wi*8 + k];
          ex_ones += int'(ew[k]);
        end
        chk("rnd_data", data_o, ew);
        chk("rnd_ones", ones_o, ex_ones);
        chk("rnd_len",  len_o, 8);
        wi++;
      end
    end
    val_i = 1'b0;
    chk("rnd_words_seen", wi, 3);
    chk("rnd_rdy_low",    low, 3);
    chk("rnd_accepted",   idx, 24);
    chk("rnd_words",      words_o, 8);

    // reset mid-operation: word held at output, 4 more collected
    rdy_i = 1'b0;
    feed8(8'hFF);
    step();
    for (int k = 0; k < 4; k++) begin
      val_i = 1'b1; Y_i = 1'b1;
      step();
    end
    val_i = 1'b0;
    chk("mr_pre_val", val_o, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_val",   val_o, 0);
    chk("mr_data",  data_o, 0);
    chk("mr_len",   len_o, 0);
    chk("mr_ones",  ones_o, 0);
    chk("mr_words", words_o, 0);
    chk("mr_rdy",   rdy_o, 1);
    rdy_i = 1'b1;
    feed8(8'h5A);
    step();
    chk("mr_new_data", data_o, 8'h5A);
    chk("mr_new_len",  len_o, 8);
    chk("mr_new_ones", ones_o, 4);
    step();
    chk("mr_new_words", words_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perceptron_out_pack.md
# perceptron_out_pack

Downstream stage of the perceptron top level. It consumes the 1-bit decision stream (`Y` qualified by `val`/`rdy`) and packs consecutive decisions into a PACK-bit word. Each word is emitted with its valid-bit length and popcount over a val/rdy output handshake. A flush request emits a partially filled word, so a batch can end at any sample count.

## Interface
- PACK, 8: decisions per output word; must be ≥ 2.
- LW, $clog2(PACK+1): width of the length and popcount fields (derived, not overridden).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- val_i  in  1  decision valid from the perceptron.
- rdy_o  out  1  this block can accept a decision.
- Y_i  in  1  decision bit.
- flush_i  in  1  single-cycle pulse: emit the current partial word.
- val_o  out  1  output word valid.
- rdy_i  in  1  downstream ready.
- data_o  out  PACK  packed decisions; first-accepted decision in bit 0, unused upper bits 0.
- len_o  out  LW  number of valid bits in data_o (1..PACK).
- ones_o  out  LW  popcount of the valid bits of data_o.
- words_o  out  16  count of completed output handshakes; wraps 0xFFFF→0.

## Operation
Internal state:
- acc[PACK-1:0]: collect register.
- cnt (0..PACK): number of decisions held in acc.
- ones_acc: running popcount of acc.
- flush_pend: sticky flush flag.

Input accept:
- rdy_o = (cnt < PACK) && !flush_pend. This is combinational from registers only.
- On accept (val_i && rdy_o): acc[cnt] ← Y_i, cnt ← cnt+1, and ones_acc ← ones_acc + Y_i.

Flush:
- flush_i sets flush_pend if (cnt > 0) or an accept occurs in the same cycle.
- If cnt == 0 and no accept occurs that cycle, flush_i is ignored.
- An accept in the same cycle as flush_i is included in the flushed word.

Transfer:
- Condition T = (cnt == PACK || (flush_pend && cnt > 0)) && (!val_o || rdy_i).
- On T:
  - data_o ← acc with bits ≥ cnt zeroed.
  - len_o ← cnt, ones_o ← ones_acc, val_o ← 1.
  - acc ← 0, cnt ← 0, ones_acc ← 0, flush_pend ← 0.
- No accept can coincide with T. rdy_o is 0 when cnt == PACK or flush_pend is set.

Output:
- val_o holds, and data_o/len_o/ones_o stay stable, until val_o && rdy_i.
- On that handshake: words_o increments, and val_o clears unless T reloads it on the same edge.
- Back-to-back words therefore need no idle cycle on the output side.

Reset (mid-operation included):
- acc, cnt, ones_acc, flush_pend, val_o, data_o, len_o, ones_o and words_o all go to 0.
- A partially collected word is discarded.
- rdy_o = 1 in the first cycle after reset.

## Timing
- Full word: the PACK-th accept happens at edge E. cnt == PACK during the following cycle. T fires at edge E+1 if the output register is free. val_o is high from E+1.
- Flush: flush_i at edge E (with cnt > 0 after E) → flush_pend set → T at E+1 → val_o high from E+1.
- Sustained throughput with rdy_i held at 1: PACK decisions per PACK+1 cycles. rdy_o is low for exactly one cycle per word.
- Output stall: if val_o is held (rdy_i = 0) when acc fills, cnt stays at PACK and rdy_o stays 0. T fires on the edge that completes the output handshake; there is no lost or duplicated word.
- flush_i while flush_pend is already set: no effect.
- flush_i while cnt == PACK: no effect. The full word transfers normally.
- words_o wraps silently.

## Test plan
- Reset, then 8 accepts of Y = 1,0,1,1,0,0,0,1 with rdy_i = 1 → data_o = 0x8D, len_o = 8, ones_o = 4, val_o high 1 cycle after the 8th accept, words_o = 1 after the handshake.
- 3 accepts (1,1,0), then a flush_i pulse → data_o = 0x03, len_o = 3, ones_o = 2. flush_i with cnt = 0 and val_i = 0 → no output and no state change.
- flush_i in the same cycle as the 5th accept of 5 ones → one word: data_o = 0x1F, len_o = 5, ones_o = 5.
- rdy_i = 0 while 8 more decisions arrive → rdy_o drops when cnt = 8 and the first word is held stable. Raise rdy_i for 1 cycle → the first word is taken and the second word appears on the next edge. words_o counts 2 with no loss.
- 24 random decisions with rdy_i = 1 and val_i = 1 continuous → 3 words matching a reference model. rdy_o is low exactly 3 cycles in total.
- Assert reset with cnt = 4 and val_o = 1 → all outputs 0 next cycle, rdy_o = 1. The next 8 decisions form a fresh word starting at bit 0.
